// File: rtl/fila_pkg.sv
// Shared types and constants for the queue arbiter and the 8x8 queue it drives.
package fila_pkg;

    localparam int DATA_W     = 8;
    localparam int FILA_DEPTH = 8;
    localparam int LEN_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_A = 2'd0,
        GNT_B = 2'd1,
        GNT_R = 2'd2
    } gnt_t;

    // Round-robin successor in the order A -> B -> R -> A.
    function automatic gnt_t next_gnt(input gnt_t g);
        case (g)
            GNT_A:   return GNT_B;
            GNT_B:   return GNT_R;
            default: return GNT_A;
        endcase
    endfunction

endpackage

// File: rtl/arbitro_fila_rr_pick3.sv
// Combinational 3-way round-robin picker: one-hot grant of the first eligible bit
// starting at the pointer (bit 0 = A, bit 1 = B, bit 2 = R).
module rr_pick3
    import fila_pkg::*;
(
    input  logic [2:0] eligible,
    input  gnt_t       ptr,
    output logic [2:0] grant
);

    logic [2:0] rot;
    logic [2:0] pick;

    // Rotate so the pointer lands on bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot = eligible;
        case (ptr)
            GNT_B:   rot = {eligible[0], eligible[2], eligible[1]};
            GNT_R:   rot = {eligible[1], eligible[0], eligible[2]};
            default: rot = eligible;
        endcase

        pick = rot[0] ? 3'b001 :
               rot[1] ? 3'b010 :
               rot[2] ? 3'b100 : 3'b000;

        grant = pick;
        case (ptr)
            GNT_B:   grant = {pick[1], pick[0], pick[2]};
            GNT_R:   grant = {pick[0], pick[2], pick[1]};
            default: grant = pick;
        endcase
    end

endmodule

// File: rtl/arbitro_fila.sv
// Round-robin controller sharing one queue between producers A/B and consumer R.
// Optional stall counter output enabled by defining ARBITRO_FILA_STATS_EN.
module arbitro_fila
    import fila_pkg::*;
#(
    parameter int DEPTH         = FILA_DEPTH,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clock_10KHz,
    input  logic              reset,
    input  logic              req_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              ack_b,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] q_data_in,
    output logic              q_enqueue,
    output logic              q_dequeue,
    input  logic [DATA_W-1:0] q_data_out,
    input  logic [LEN_W-1:0]  q_len,
`ifdef ARBITRO_FILA_STATS_EN
    output logic [7:0]        stall_count,
`endif
    output logic              busy
);

    state_t     state;
    gnt_t       ptr;
    gnt_t       gnt_id;
    logic [3:0] settle_cnt;
    logic [2:0] eligible;
    logic [2:0] grant;
    logic       wr_room;
    logic       rd_avail;
    logic       q_full;

    assign q_full   = (q_len == LEN_W'(DEPTH));
    assign wr_room  = (q_len <  LEN_W'(DEPTH));
    assign rd_avail = (q_len != '0);

    // A requester whose completion pulse is showing right now is ignored, so a
    // one-cycle-late request drop cannot cause a second service.
    assign eligible = {rd_req & ~rd_valid & rd_avail,
                       req_b  & ~ack_b    & wr_room,
                       req_a  & ~ack_a    & wr_room};

    rr_pick3 u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (grant)
    );

    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= GNT_A;
            gnt_id     <= GNT_A;
            settle_cnt <= '0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            q_data_in  <= '0;
            q_enqueue  <= 1'b0;
            q_dequeue  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            rd_valid  <= 1'b0;
            q_enqueue <= 1'b0;
            q_dequeue <= 1'b0;
            case (state)
                IDLE: begin
                    // Command outputs are loaded on the grant edge so they are
                    // presented to the queue for exactly the ISSUE cycle.
                    if (|grant) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                        if (grant[0]) begin
                            gnt_id    <= GNT_A;
                            q_data_in <= data_a;
                            q_enqueue <= 1'b1;
                        end else if (grant[1]) begin
                            gnt_id    <= GNT_B;
                            q_data_in <= data_b;
                            q_enqueue <= 1'b1;
                        end else begin
                            gnt_id    <= GNT_R;
                            q_dequeue <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state      <= SETTLE;
                    settle_cnt <= '0;
                end
                SETTLE: begin
                    if (settle_cnt == 4'(SETTLE_CYCLES - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ptr   <= next_gnt(gnt_id);
                        case (gnt_id)
                            GNT_A: ack_a <= 1'b1;
                            GNT_B: ack_b <= 1'b1;
                            default: begin
                                rd_data  <= q_data_out;
                                rd_valid <= 1'b1;
                            end
                        endcase
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARBITRO_FILA_STATS_EN
    // Cycles a producer is kept waiting by a full queue, saturating at 255.
    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (state == IDLE && (req_a || req_b) && q_full && stall_count != 8'hFF) begin
            stall_count <= stall_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arbitro_fila.sv
// Self-checking bench for arbitro_fila: directed scenarios plus randomized traffic
// against a transaction-level arbitration model and a behavioural queue.
`timescale 1us/1ns
module tb_arbitro_fila;
    localparam int S = 2;

    logic       clock_10KHz = 1'b0;
    logic       reset = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0, rd_req = 1'b0;
    logic [7:0] data_a = '0, data_b = '0, q_data_out = '0;
    logic [3:0] q_len = '0;
    logic       ack_a, ack_b, rd_valid, q_enqueue, q_dequeue, busy;
    logic [7:0] rd_data, q_data_in;
`ifdef ARBITRO_FILA_STATS_EN
    logic [7:0] stall_count;
`endif
    logic [21:0] all_outs;
    int checks = 0;
    int failures = 0;

    assign all_outs = {ack_a, ack_b, rd_valid, q_enqueue, q_dequeue, busy, rd_data, q_data_in};

    always #50 clock_10KHz = ~clock_10KHz;

    arbitro_fila #(.DEPTH(8), .SETTLE_CYCLES(S)) dut (
        .clock_10KHz (clock_10KHz),
        .reset       (reset),
        .req_a       (req_a),
        .data_a      (data_a),
        .ack_a       (ack_a),
        .req_b       (req_b),
        .data_b      (data_b),
        .ack_b       (ack_b),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .q_data_in   (q_data_in),
        .q_enqueue   (q_enqueue),
        .q_dequeue   (q_dequeue),
        .q_data_out  (q_data_out),
        .q_len       (q_len),
`ifdef ARBITRO_FILA_STATS_EN
        .stall_count (stall_count),
`endif
        .busy        (busy)
    );

    task automatic tick();
        @(posedge clock_10KHz);
        #1;
    endtask

    // Leaves the bench at cycle 0: reset released just after an edge, inputs idle.
    task automatic do_reset();
        req_a = 0; req_b = 0; rd_req = 0;
        data_a = '0; data_b = '0; q_data_out = '0; q_len = '0;
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        checks++;
        if (all_outs !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
`ifdef ARBITRO_FILA_STATS_EN
        checks++;
        if (stall_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_stall_count: got %0d expected 0", stall_count);
        end
`endif
        do_reset();
    endtask

    task automatic test_single_write();
        do_reset();
        data_a = 8'h5A;
        req_a  = 1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++;
            if (q_enqueue !== (c == 1) || q_dequeue !== 1'b0 || busy !== (c >= 1 && c <= 1 + S)
                || ack_a !== (c == 2 + S) || ack_b !== 1'b0) begin
                failures++;
                $display("FAIL single_write cycle %0d: got enq=%b deq=%b busy=%b ack_a=%b ack_b=%b expected enq=%b busy=%b ack_a=%b",
                         c, q_enqueue, q_dequeue, busy, ack_a, ack_b, c == 1, c >= 1 && c <= 1 + S, c == 2 + S);
            end
            if (c == 1) begin
                checks++;
                if (q_data_in !== 8'h5A) begin
                    failures++;
                    $display("FAIL single_write_data: got %h expected 5a", q_data_in);
                end
            end
            if (ack_a) req_a = 0;
        end
    endtask

    task automatic test_round_robin();
        int ids[4];
        int cyc[4];
        int n = 0;
        int exp_ids[4] = '{0, 1, 2, 0};
        do_reset();
        q_len = 4'd3; q_data_out = 8'h77;
        data_a = 8'hA1; data_b = 8'hB2;
        req_a = 1; req_b = 1; rd_req = 1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            req_a = 1; req_b = 1; rd_req = 1;
            if ((ack_a || ack_b || rd_valid) && n < 4) begin
                ids[n] = ack_a ? 0 : (ack_b ? 1 : 2);
                cyc[n] = c;
                n++;
            end
            if (rd_valid) begin
                checks++;
                if (rd_data !== 8'h77) begin
                    failures++;
                    $display("FAIL rr_rd_data: got %h expected 77", rd_data);
                end
            end
            if (ack_a) req_a = 0;
            if (ack_b) req_b = 0;
            if (rd_valid) rd_req = 0;
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL rr_count: got %0d completions expected 4", n);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (ids[k] != exp_ids[k] || cyc[k] != 4 * (k + 1)) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: got id=%0d cycle=%0d expected id=%0d cycle=%0d",
                             k, ids[k], cyc[k], exp_ids[k], 4 * (k + 1));
                end
            end
        end
        req_a = 0; req_b = 0; rd_req = 0;
    endtask

    task automatic test_full();
        logic deq_seen = 0;
        do_reset();
        q_len = 4'd8; q_data_out = 8'h11;
        data_a = 8'hE1; req_a = 1; rd_req = 1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (deq_seen) q_len = 4'd7;
            checks++;
            if ((q_enqueue && q_len == 4'd8) || rd_valid !== (c == 4) || ack_a !== (c == 8)) begin
                failures++;
                $display("FAIL full_queue cycle %0d: got enq=%b q_len=%0d rd_valid=%b ack_a=%b expected rd_valid=%b ack_a=%b",
                         c, q_enqueue, q_len, rd_valid, ack_a, c == 4, c == 8);
            end
            if (rd_valid) begin
                checks++;
                if (rd_data !== 8'h11) begin
                    failures++;
                    $display("FAIL full_rd_data: got %h expected 11", rd_data);
                end
            end
            if (q_dequeue) deq_seen = 1;
            if (rd_valid) rd_req = 0;
            if (ack_a) req_a = 0;
        end
    endtask

    task automatic test_empty();
        do_reset();
        rd_req = 1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            checks++;
            if (q_dequeue || rd_valid || busy) begin
                failures++;
                $display("FAIL empty_skip cycle %0d: got deq=%b rd_valid=%b busy=%b expected 0 0 0", c, q_dequeue, rd_valid, busy);
            end
        end
        q_len = 4'd1; q_data_out = 8'hC3;
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++;
            if (q_dequeue !== (c == 1) || rd_valid !== (c == 4) || q_enqueue !== 1'b0) begin
                failures++;
                $display("FAIL empty_then_read cycle %0d: got deq=%b rd_valid=%b enq=%b expected deq=%b rd_valid=%b",
                         c, q_dequeue, rd_valid, q_enqueue, c == 1, c == 4);
            end
            if (rd_valid) begin
                checks++;
                if (rd_data !== 8'hC3) begin
                    failures++;
                    $display("FAIL empty_rd_data: got %h expected c3", rd_data);
                end
                rd_req = 0;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        data_a = 8'h3C; req_a = 1;
        tick();
        tick();
        #10;
        reset = 1;
        #1;
        checks++;
        if (all_outs !== 22'd0) begin
            failures++;
            $display("FAIL reset_mid_async: got %h expected 0", all_outs);
        end
        tick();
        checks++;
        if (all_outs !== 22'd0) begin
            failures++;
            $display("FAIL reset_mid_held: got %h expected 0", all_outs);
        end
        reset = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (q_enqueue !== (c == 1) || ack_a !== (c == 4) || busy !== (c >= 1 && c <= 3)) begin
                failures++;
                $display("FAIL reset_restart cycle %0d: got enq=%b ack_a=%b busy=%b expected enq=%b ack_a=%b busy=%b",
                         c, q_enqueue, ack_a, busy, c == 1, c == 4, c >= 1 && c <= 3);
            end
            if (ack_a) req_a = 0;
        end
    endtask

`ifdef ARBITRO_FILA_STATS_EN
    task automatic test_stats();
        do_reset();
        q_len = 4'd8; req_b = 1;
        repeat (10) tick();
        checks++;
        if (stall_count !== 8'd10) begin
            failures++;
            $display("FAIL stall_count_10: got %0d expected 10", stall_count);
        end
        repeat (290) tick();
        checks++;
        if (stall_count !== 8'd255) begin
            failures++;
            $display("FAIL stall_count_sat: got %0d expected 255", stall_count);
        end
        req_b = 0;
    endtask
`endif

    // Model: while free, grant the first eligible requester from the pointer;
    // that transaction occupies cycles g+1..g+2+S and completes at g+2+S.
    task automatic test_random();
        byte unsigned mq[$];
        byte unsigned ref_q[$];
        int g = -1000, gid = 0, ptr = 0, free_at = 0, rd_div;
        logic [7:0] gdata = '0, exp_rd = '0, pend_byte = '0;
        logic pend_enq = 0, pend_deq = 0;
        logic e_enq, e_deq, e_busy, e_aa, e_ab, e_rv, done;
        logic [2:0] el;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if (n > 0) tick();
            if (pend_enq) mq.push_back(pend_byte);
            if (pend_deq && mq.size() > 0) q_data_out = mq.pop_front();
            q_len = 4'(mq.size());
            e_busy = (n >= g + 1) && (n <= g + 1 + S);
            e_enq  = (n == g + 1) && (gid != 2);
            e_deq  = (n == g + 1) && (gid == 2);
            e_aa   = (n == g + 2 + S) && (gid == 0);
            e_ab   = (n == g + 2 + S) && (gid == 1);
            e_rv   = (n == g + 2 + S) && (gid == 2);
            checks++;
            if ({q_enqueue, q_dequeue, busy, ack_a, ack_b, rd_valid} !== {e_enq, e_deq, e_busy, e_aa, e_ab, e_rv}) begin
                failures++;
                $display("FAIL random_ctrl cycle %0d: got enq,deq,busy,ack_a,ack_b,rd_valid=%b expected %b",
                         n, {q_enqueue, q_dequeue, busy, ack_a, ack_b, rd_valid}, {e_enq, e_deq, e_busy, e_aa, e_ab, e_rv});
            end
            if (e_enq) begin
                checks++;
                if (q_data_in !== gdata) begin
                    failures++;
                    $display("FAIL random_wdata cycle %0d: got %h expected %h", n, q_data_in, gdata);
                end
            end
            if (e_rv) begin
                checks++;
                if (rd_data !== exp_rd) begin
                    failures++;
                    $display("FAIL random_rdata cycle %0d: got %h expected %h", n, rd_data, exp_rd);
                end
            end
            pend_enq = q_enqueue; pend_deq = q_dequeue; pend_byte = q_data_in;

            rd_div = (n < 700) ? 10 : 1;
            if (ack_a) req_a = 0;
            else if (!req_a && $urandom_range(3) == 0) begin req_a = 1; data_a = 8'($urandom); end
            if (ack_b) req_b = 0;
            else if (!req_b && $urandom_range(3) == 0) begin req_b = 1; data_b = 8'($urandom); end
            if (rd_valid) rd_req = 0;
            else if (!rd_req && $urandom_range(rd_div) == 0) rd_req = 1;

            if (n >= free_at) begin
                el[0] = req_a && !e_aa && ref_q.size() < 8;
                el[1] = req_b && !e_ab && ref_q.size() < 8;
                el[2] = rd_req && !e_rv && ref_q.size() > 0;
                done = 0;
                for (int k = 0; k < 3; k++) begin
                    int id;
                    id = (ptr + k) % 3;
                    if (el[id] && !done) begin
                        done = 1;
                        g = n; gid = id; free_at = n + 2 + S; ptr = (id + 1) % 3;
                        if (id == 2) exp_rd = ref_q.pop_front();
                        else begin
                            gdata = (id == 0) ? data_a : data_b;
                            ref_q.push_back(gdata);
                        end
                    end
                end
            end
        end
        req_a = 0; req_b = 0; rd_req = 0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_full();
        test_empty();
        test_reset_mid();
`ifdef ARBITRO_FILA_STATS_EN
        test_stats();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
